uart_receiver: RTL and testbench
================================

# uart_receiver

Serial receiver for the 11-bit UART frame produced by the team's transmitter: start bit (0), 8 data bits LSB first, even parity bit, stop bit (1), at 9600 baud from a 100 MHz clock. It synchronises the asynchronous `rx` pin and detects the start bit with mid-bit verification. Each bit is sampled at its centre. Each received byte is presented with a one-cycle valid strobe and parity/framing status. It sits at the FPGA pin boundary, opposite `uart_transmitter`, and the pair are looped back for board test.

## Interface
- `BAUD_RATE`, 9600, line rate in bits/s
- `CLK_FREQ`, 100_000_000, `clk` frequency in Hz
- `CLKS_PER_BIT`, CLK_FREQ / BAUD_RATE (10416), clock cycles per bit
- `HALF_BIT`, CLKS_PER_BIT / 2 (5208), cycles from start-bit edge to start-bit centre
- `LED_CYCLES`, 5_000_000, LED on-time after a good frame (50 ms)

- `clk`  input  1  100 MHz clock; all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `rx`  input  1  serial line, asynchronous to `clk`, idles high
- `data_out`  output  8  last received data byte
- `rx_valid`  output  1  one-cycle pulse: `data_out`/`parity_err`/`frame_err` updated
- `parity_err`  output  1  last frame failed even-parity check
- `frame_err`  output  1  last frame's stop bit sampled 0
- `rx_busy`  output  1  high in any state other than IDLE
- `led`  output  1  high for LED_CYCLES after a frame with no errors

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1); all logic uses synchronised `rx_s`.
- Bit counter: 14 bits wide, covering 0..10415. Bit index: 4 bits wide. Data shift register: 8 bits, shifts right with the new bit entering at bit 7, giving LSB-first order.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when `rx_s`==0, clear the counter and go to START.
- START: count to HALF_BIT-1, then sample.
  - `rx_s`==0: clear the counter and go to DATA.
  - `rx_s`==1: false start; go to IDLE with no outputs changed.
- DATA: count to CLKS_PER_BIT-1, then sample into the shift register and clear the counter. After the 8th sample, go to PARITY.
- PARITY: at the CLKS_PER_BIT-1 count, sample the parity bit. `parity_err` is the XOR of the 8 data bits and the parity bit (nonzero means error). Go to STOP.
- STOP: at the CLKS_PER_BIT-1 count (stop-bit centre), sample the stop bit, then load the outputs and pulse `rx_valid`.
  - Stop bit 1: go to IDLE, so the receiver can accept the next start edge within the second half of the stop bit.
  - Stop bit 0: set `frame_err`=1 and go to WAIT_HIGH.
- WAIT_HIGH: remain until `rx_s`==1, then go to IDLE. A held-low line (break) produces exactly one `rx_valid` and no spurious frames.
- `rx_valid` pulses for every frame that reaches STOP, including frames with errors. `data_out`, `parity_err` and `frame_err` hold their values until the next `rx_valid`.
- LED: on a frame with no errors, load `led_counter` with LED_CYCLES. While the counter is nonzero, `led`=1 and the counter decrements. A new good frame reloads the counter.
- Reset is legal at any time, including mid-frame. It forces IDLE and clears all counters.

## Timing
- Reset values: `data_out`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0, `led`=0, state IDLE, synchroniser flops=1.
- Registers update on the clock edge and are visible on the following cycle.
- Let cycle T be the first `clk` edge at which the raw `rx` is low:
  - `rx_s` goes low at T+2, and START is entered at T+3.
  - The start bit is sampled at T+3+HALF_BIT-1.
  - Data bit k is sampled CLKS_PER_BIT×(k+1) cycles after the start sample; parity at ×9, stop at ×10.
  - `rx_valid`, `data_out` and the flags are visible at T+3+HALF_BIT+10×CLKS_PER_BIT, i.e. 109,371 cycles with defaults.
- `rx_busy` rises with START entry and falls on the cycle `rx_valid` is high (IDLE return) or on WAIT_HIGH exit.
- There is no backpressure. A consumer must take `data_out` before the next `rx_valid`, one frame later at minimum (≥114,576 cycles).

## Test plan
- Drive frame 0xA5 (parity 0, stop 1) at 10416 cycles/bit -> one `rx_valid` pulse; `data_out`=0xA5, `parity_err`=0, `frame_err`=0; `led`=1 for 5,000,000 cycles.
- Drive data 0x01 with parity bit 0 -> `data_out`=0x01, `parity_err`=1, `frame_err`=0; `led` stays 0.
- Pull `rx` low for 2000 cycles, then high -> no `rx_valid`; `rx_busy` returns to 0 after HALF_BIT cycles; the next valid frame 0x3C is received correctly.
- Drive frame 0x55 with stop bit 0, then hold `rx` low for 3 bit times -> exactly one `rx_valid` with `frame_err`=1; no further pulses until `rx` is high and a new frame 0x0F arrives (received with both flags 0).
- Assert `rst_n`=0 during data bit 4, then release and send 0xC3 -> all outputs are at reset values during reset; 0xC3 is received cleanly with no partial-frame pulse.
- Loop `uart_transmitter.tx` to `rx` and send 0x00, 0xFF, 0x81 back to back -> three `rx_valid` pulses with matching bytes and no errors.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle for uart_receiver.
// The receiver drives the master modport and its consumer uses the slave modport.
// Handshake: rx_valid is a one-cycle strobe with no ready or backpressure.
// data_out, parity_err and frame_err change only in the cycle rx_valid is high.
// They hold their values until the next strobe.
interface uart_receiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;
    logic       led;
    logic [2:0] dbg_state;

    modport master (
        input  rx,
        output data_out, rx_valid, parity_err, frame_err, rx_busy, led, dbg_state
    );

    modport slave (
        output rx,
        input  data_out, rx_valid, parity_err, frame_err, rx_busy, led, dbg_state
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver for the 11-bit frame: start(0), 8 data bits LSB first, even parity, stop(1).
// The start bit is verified at its centre, and every later bit is sampled at its centre.
// Each frame that reaches the stop bit produces one rx_valid pulse with parity and framing status.
module uart_receiver #(
    parameter int BAUD_RATE    = 9600,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int LED_CYCLES   = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    uart_receiver_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int LED_W = $clog2(LED_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             parity_bad;
    logic [7:0]       data_r;
    logic             valid_r;
    logic             perr_r;
    logic             ferr_r;
    logic             busy_r;
    logic [LED_W-1:0] led_cnt;

    // Two-flop synchroniser for the asynchronous pin; it idles high so reset does not look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with its bit timing, data shifting, registered outputs and LED hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bad <= 1'b0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
            led_cnt    <= '0;
        end else begin
            valid_r <= 1'b0;
            if (led_cnt != '0) begin
                led_cnt <= led_cnt - LED_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        busy_r  <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            // The line came back high before mid-start: treat it as a glitch.
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 4'd7) begin
                            state <= S_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt    <= '0;
                        parity_bad <= (^shift_reg) ^ rx_s;
                        state      <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        data_r  <= shift_reg;
                        perr_r  <= parity_bad;
                        ferr_r  <= ~rx_s;
                        valid_r <= 1'b1;
                        if (rx_s) begin
                            // Returning to IDLE at the stop-bit centre lets a back-to-back start edge be caught.
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                            if (!parity_bad) begin
                                led_cnt <= LED_W'(LED_CYCLES);
                            end
                        end else begin
                            state <= S_WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A break keeps the line low, so wait here for it to return high before looking for a start bit.
                    if (rx_s) begin
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_r;
    assign bus.rx_valid   = valid_r;
    assign bus.parity_err = perr_r;
    assign bus.frame_err  = ferr_r;
    assign bus.rx_busy    = busy_r;
    assign bus.led        = (led_cnt != '0);
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver, run with a short bit period: 16 clocks per bit and a 200-cycle LED hold.
// Expected frames are derived from the bits driven on the line and placed on a timed queue.
// A negedge process compares every output against that model on every cycle.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LEDC = 200;
    // Edges from the first low raw edge T to the edge that registers rx_valid: 2 sync + HALF + 10 bits.
    localparam int LAT  = 2 + HALF + 10 * CPB;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_valid = 0;
    int   last_valid_cyc = 0;

    // Expected frame: {valid edge number[41:10], data[9:2], parity_err[1], frame_err[0]}.
    logic [41:0] exp_q[$];
    logic [41:0] e;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        m_ferr;
    logic        exp_v;
    int          led_left;

    uart_receiver_if bus ();

    uart_receiver #(
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_600_000),
        .LED_CYCLES(LEDC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock and cycle counter; cyc holds the number of rising edges seen so far.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: the model's outputs, compared against the DUT on every falling edge.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            check("rst_data_out", 32'(bus.data_out), 32'h0);
            check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
            check("rst_parity_err", 32'(bus.parity_err), 32'h0);
            check("rst_frame_err", 32'(bus.frame_err), 32'h0);
            check("rst_rx_busy", 32'(bus.rx_busy), 32'h0);
            check("rst_led", 32'(bus.led), 32'h0);
            m_data   = 8'h00;
            m_perr   = 1'b0;
            m_ferr   = 1'b0;
            led_left = 0;
            exp_q.delete();
        end else begin
            exp_v = 1'b0;
            if (exp_q.size() > 0 && exp_q[0][41:10] == 32'(cyc)) begin
                e      = exp_q.pop_front();
                exp_v  = 1'b1;
                m_data = e[9:2];
                m_perr = e[1];
                m_ferr = e[0];
                if (!m_perr && !m_ferr) led_left = LEDC;
            end
            if (bus.rx_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            check("rx_valid", 32'(bus.rx_valid), 32'(exp_v));
            check("data_out", 32'(bus.data_out), 32'(m_data));
            check("parity_err", 32'(bus.parity_err), 32'(m_perr));
            check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
            check("led", 32'(bus.led), 32'(led_left > 0));
            if (led_left > 0) led_left--;
        end
    end

    // Driver tasks. Every task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [10:0] bits, input int n);
        for (int j = 0; j < n; j++) begin
            bus.rx = bits[j];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int t0);
        t0 = cyc + 1;
        exp_q.push_back({32'(t0 + LAT), d, (^d) ^ p, ~s});
        drive_bits({s, p, d, 1'b0}, 11);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    int         t0;
    int         v0;
    logic [7:0] rd;
    logic       rp;
    logic       rs;

    // Main stimulus sequence.
    initial begin
        rst_n  = 1'b1;
        bus.rx = 1'b1;
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // Good frame 0xA5: valid 170 edges after T, then the LED stays on for exactly 200 cycles.
        v0 = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        check("a5_pulses", 32'(n_valid - v0), 32'd1);
        check("a5_latency", 32'(last_valid_cyc - t0), 32'd170);
        check("a5_data", 32'(bus.data_out), 32'hA5);
        check("a5_perr", 32'(bus.parity_err), 32'h0);
        wait_cycle(t0 + 170 + 199);
        check("a5_led_last", 32'(bus.led), 32'h1);
        wait_cycle(t0 + 170 + 200);
        check("a5_led_off", 32'(bus.led), 32'h0);
        @(posedge clk);
        #1;

        // 0x01 sent with parity bit 0 must be reported as a parity error.
        send_frame(8'h01, 1'b0, 1'b1, t0);
        check("p01_data", 32'(bus.data_out), 32'h01);
        check("p01_perr", 32'(bus.parity_err), 32'h1);
        check("p01_ferr", 32'(bus.frame_err), 32'h0);
        check("p01_led", 32'(bus.led), 32'h0);

        // A short low glitch is a false start: busy for HALF cycles, then no pulse.
        idle(5);
        v0 = n_valid;
        t0 = cyc + 1;
        bus.rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        wait_cycle(t0 + 2 + HALF - 1);
        check("glitch_busy", 32'(bus.rx_busy), 32'h1);
        wait_cycle(t0 + 2 + HALF);
        check("glitch_idle", 32'(bus.rx_busy), 32'h0);
        @(posedge clk);
        #1;
        idle(5);
        send_frame(8'h3C, 1'b0, 1'b1, t0);
        check("glitch_pulses", 32'(n_valid - v0), 32'd1);
        check("3c_data", 32'(bus.data_out), 32'h3C);

        // Stop bit 0 followed by a 3-bit break: exactly one pulse, with frame_err set.
        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b0, t0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("break_busy", 32'(bus.rx_busy), 32'h1);
        check("break_ferr", 32'(bus.frame_err), 32'h1);
        idle(5);
        check("break_pulses", 32'(n_valid - v0), 32'd1);
        check("break_idle", 32'(bus.rx_busy), 32'h0);
        send_frame(8'h0F, 1'b0, 1'b1, t0);
        check("0f_data", 32'(bus.data_out), 32'h0F);
        check("0f_ferr", 32'(bus.frame_err), 32'h0);

        // Reset during data bit 4, then a clean 0xC3 frame.
        idle(5);
        v0 = n_valid;
        drive_bits({1'b1, 1'b0, 8'hC3, 1'b0}, 5);
        bus.rx = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        send_frame(8'hC3, 1'b0, 1'b1, t0);
        check("c3_pulses", 32'(n_valid - v0), 32'd1);
        check("c3_data", 32'(bus.data_out), 32'hC3);

        // Back-to-back frames with no idle gap, as a looped-back transmitter would send them.
        v0 = n_valid;
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t0);
        send_frame(8'h81, 1'b0, 1'b1, t0);
        check("b2b_pulses", 32'(n_valid - v0), 32'd3);
        check("b2b_data", 32'(bus.data_out), 32'h81);

        // Random frames with occasional bad parity or stop bits and random idle gaps.
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 6) != 0);
            send_frame(rd, rp, rs, t0);
            idle($urandom_range(2, 12));
        end

        idle(300);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
